mem_lsu: RTL

Load/store unit between the core's data port and a word-addressed, handshaked data RAM. It converts the core's byte-addressed, right-justified load/store requests into aligned word accesses with shifted byte enables. It stalls the core until the memory acknowledges, and returns right-justified load data for the core's sign/zero extension. It flags misaligned accesses and memory timeouts instead of issuing them.

---
 rtl/mem_lsu_pkg.sv | 30 +++
 rtl/mem_lsu_align.sv | 32 +++
 rtl/mem_lsu.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/mem_lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, access sizes
// and byte-enable mask validation.
package mem_lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Only byte, half and word masks in the low lanes are legal.
    function automatic logic be_valid(input logic [3:0] be);
        return (be == 4'b0001) || (be == 4'b0011) || (be == 4'b1111);
    endfunction

    // Right-justified lane mask for a load size; the reserved size maps to an illegal mask.
    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            SZ_BYTE: return 4'b0001;
            SZ_HALF: return 4'b0011;
            SZ_WORD: return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Lane steering for the load/store unit: shifts store enables/data into the
// addressed word lanes, right-justifies load data and flags misalignment.
module lsu_align
    import mem_lsu_pkg::*;
(
    input  logic        is_store,
    input  logic [1:0]  read_size,
    input  logic [3:0]  byte_enable,
    input  logic [31:0] write_data,
    input  logic [1:0]  off,
    input  logic [1:0]  load_off,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [3:0] mask;

    always_comb begin
        mask       = is_store ? byte_enable : size_mask(read_size);
        mem_be     = 4'(mask << off);
        mem_wdata  = is_store ? 32'(write_data << {off, 3'b000}) : 32'd0;
        load_data  = mem_rdata >> {load_off, 3'b000};
        // A size is inferred from the mask, so one check covers loads and stores.
        misaligned = !be_valid(mask)
                   || ((mask == 4'b0011) && off[0])
                   || ((mask == 4'b1111) && (off != 2'b00));
    end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit: turns byte-addressed core requests into aligned, handshaked
// word accesses and stalls the core until the RAM answers or times out.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int unsigned MEM_ADDR_WIDTH = 14,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clk_en,
    input  logic                      i_read_req,
    input  logic [1:0]                i_read_size,
    input  logic [31:0]               i_read_addr,
    output logic [31:0]               o_read_data,
    input  logic                      i_write_enable,
    input  logic [3:0]                i_byte_enable,
    input  logic [31:0]               i_write_addr,
    input  logic [31:0]               i_write_data,
    output logic                      o_stall,
    output logic                      o_misaligned,
    output logic                      o_bus_error,
    output logic                      o_mem_req,
    output logic                      o_mem_we,
    output logic [MEM_ADDR_WIDTH-1:0] o_mem_addr,
    output logic [3:0]                o_mem_be,
    output logic [31:0]               o_mem_wdata,
    input  logic                      i_mem_ack,
    input  logic [31:0]               i_mem_rdata
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d, cnt_inc;
    logic [1:0]                off_q, off_d;
    logic                      req_d, we_d, mis_d, berr_d, timeout;
    logic [MEM_ADDR_WIDTH-1:0] addr_d;
    logic [3:0]                be_d, al_be;
    logic [31:0]               wdata_d, rdata_d, al_wdata, load_data, req_addr;
    logic                      is_store, req_any, misaligned;
    logic                      unused_addr;

    // A simultaneous load and store resolves to the store.
    assign is_store    = i_write_enable;
    assign req_any     = i_read_req | i_write_enable;
    assign req_addr    = is_store ? i_write_addr : i_read_addr;
    assign unused_addr = ^req_addr[31:MEM_ADDR_WIDTH+2];
    assign cnt_inc     = cnt_q + CNT_W'(1);
    assign timeout     = (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

    lsu_align u_align (
        .is_store    (is_store),
        .read_size   (i_read_size),
        .byte_enable (i_byte_enable),
        .write_data  (i_write_data),
        .off         (req_addr[1:0]),
        .load_off    (off_q),
        .mem_rdata   (i_mem_rdata),
        .mem_be      (al_be),
        .mem_wdata   (al_wdata),
        .load_data   (load_data),
        .misaligned  (misaligned)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        off_d   = off_q;
        req_d   = o_mem_req;
        we_d    = o_mem_we;
        addr_d  = o_mem_addr;
        be_d    = o_mem_be;
        wdata_d = o_mem_wdata;
        rdata_d = o_read_data;
        mis_d   = 1'b0;
        berr_d  = 1'b0;
        o_stall = 1'b0;
        case (state_q)
            ST_IDLE: begin
                o_stall = req_any & ~misaligned;
                if (req_any) begin
                    if (misaligned) begin
                        mis_d   = 1'b1;
                        rdata_d = 32'd0;
                        state_d = ST_DONE;
                    end else begin
                        req_d   = 1'b1;
                        we_d    = is_store;
                        addr_d  = req_addr[MEM_ADDR_WIDTH+1:2];
                        be_d    = al_be;
                        wdata_d = al_wdata;
                        off_d   = req_addr[1:0];
                        cnt_d   = '0;
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                o_stall = 1'b1;
                // An ack in the timeout cycle still counts as success.
                if (i_mem_ack) begin
                    rdata_d = o_mem_we ? 32'd0 : load_data;
                    req_d   = 1'b0;
                    state_d = ST_DONE;
                end else if (timeout) begin
                    berr_d  = 1'b1;
                    rdata_d = 32'd0;
                    req_d   = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs, all gated by the clock enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            off_q        <= 2'b00;
            o_mem_req    <= 1'b0;
            o_mem_we     <= 1'b0;
            o_mem_addr   <= '0;
            o_mem_be     <= 4'b0000;
            o_mem_wdata  <= 32'd0;
            o_read_data  <= 32'd0;
            o_misaligned <= 1'b0;
            o_bus_error  <= 1'b0;
        end else if (clk_en) begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            off_q        <= off_d;
            o_mem_req    <= req_d;
            o_mem_we     <= we_d;
            o_mem_addr   <= addr_d;
            o_mem_be     <= be_d;
            o_mem_wdata  <= wdata_d;
            o_read_data  <= rdata_d;
            o_misaligned <= mis_d;
            o_bus_error  <= berr_d;
        end
    end

endmodule
